// File: rtl/data_memory_hs.sv
// data_memory_hs: big-endian byte-addressed RAM with valid/ready requests and a registered, backpressured response.
// Optional MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of forcing alignment.
module data_memory_hs #(
   parameter int          ADDR_W    = 12,
   parameter logic [7:0]  INIT_BYTE = 8'h08
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);
   localparam int DEPTH = 2**ADDR_W;
   typedef enum logic {S_EMPTY, S_FULL} state_t;
   state_t r_state, w_next;
   logic [7:0] r_mem [DEPTH] = '{default: INIT_BYTE};
   logic [31:0] r_rdata, w_load;
   logic r_err, w_accept, w_err, w_we, w_ext;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] w_a [4];
   logic [7:0] w_b [4];
   assign req_ready = !rsp_valid || rsp_ready;
   assign w_accept  = req_valid && req_ready;
   assign rsp_valid = (r_state == S_FULL);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
`ifdef MISALIGN_TRAP_EN
   logic w_misal;
   assign w_misal = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   assign w_err   = (req_size == 2'b11) || w_misal;
   assign w_addr  = req_addr;
`else
   assign w_err  = (req_size == 2'b11);
   assign w_addr = req_size == 2'b10 ? {req_addr[ADDR_W-1:2], 2'b00} :
                   req_size == 2'b01 ? {req_addr[ADDR_W-1:1], 1'b0} : req_addr;
`endif
   assign w_we = w_accept && req_write && !w_err;
   // byte k of the access lives at a+k, wrapping naturally in ADDR_W bits
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_a[k] = w_addr + ADDR_W'(k);
         w_b[k] = r_mem[w_a[k]];
      end
   end
   assign w_ext  = req_signed & w_b[0][7];
   assign w_load = req_size == 2'b00 ? {{24{w_ext}}, w_b[0]} :
                   req_size == 2'b01 ? {{16{w_ext}}, w_b[0], w_b[1]} :
                   {w_b[0], w_b[1], w_b[2], w_b[3]};
   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = S_FULL;
      else if (rsp_ready) w_next = S_EMPTY;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_EMPTY;
      else r_state <= w_next;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_rdata <= (req_write || w_err) ? 32'h0 : w_load;
         r_err   <= w_err;
      end
   end
   always_ff @(posedge CLK) begin
      if (w_we) begin
         if (req_size == 2'b00) begin
            r_mem[w_a[0]] <= req_wdata[7:0];
         end else if (req_size == 2'b01) begin
            r_mem[w_a[0]] <= req_wdata[15:8];
            r_mem[w_a[1]] <= req_wdata[7:0];
         end else begin
            r_mem[w_a[0]] <= req_wdata[31:24];
            r_mem[w_a[1]] <= req_wdata[23:16];
            r_mem[w_a[2]] <= req_wdata[15:8];
            r_mem[w_a[3]] <= req_wdata[7:0];
         end
      end
   end
endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: directed and randomized checks of data_memory_hs against a byte-array reference model.
module tb_data_memory_hs;
   localparam int DEPTH = 4096;
   logic CLK = 0, RST = 0, req_valid = 0, req_write = 0, req_signed = 0, rsp_ready = 0;
   logic [1:0] req_size = 0;
   logic [11:0] req_addr = 0;
   logic [31:0] req_wdata = 0;
   logic req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   int n_checks = 0, n_fail = 0;
   logic [7:0] mdl [DEPTH];

   data_memory_hs dut (.CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   always #5 CLK = ~CLK;

   // Reference: plain byte array, big-endian assembly by arithmetic
   task automatic model_access(input logic w, input logic [1:0] sz, input logic sg, input int a,
                               input logic [31:0] wd, output logic [31:0] rd, output logic e);
      int n = 1 << sz;
      int base;
      longint v = 0;
      e = (sz == 2'b11);
`ifdef MISALIGN_TRAP_EN
      e = e || ((a % n) != 0);
      base = a;
`else
      base = a - (a % n);
`endif
      rd = 0;
      if (!e) begin
         if (w) begin
            for (int k = 0; k < n; k++) mdl[(base + k) % DEPTH] = 8'(wd >> (8 * (n - 1 - k)));
         end else begin
            for (int k = 0; k < n; k++) v = v * 256 + longint'(mdl[(base + k) % DEPTH]);
            if (sg && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
            rd = v[31:0];
         end
      end
   endtask

   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [11:0] a,
                         input logic [31:0] wd, output logic v, output logic [31:0] rd, output logic e);
      @(negedge CLK);
      req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      rsp_ready = 1;
      @(posedge CLK); #1;
      v = rsp_valid; rd = rsp_rdata; e = rsp_err;
      req_valid = 0;
   endtask

   task automatic test_reset();
      #2 RST = 1;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs valid=%b rdata=%h err=%b expected 0/0/0", rsp_valid, rsp_rdata, rsp_err);
      end
      @(negedge CLK); RST = 0; #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_req_ready got=%b expected 1", req_ready);
      end
   endtask

   task automatic test_loads();
      logic v, e, me;
      logic [31:0] rd, mrd;
      logic [31:0] exp_d [6] = '{32'h0, 32'hDEADBEEF, 32'h000000DE, 32'h000000EF, 32'hFFFFBEEF, 32'h0000BEEF};
      logic [1:0] sz [6] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
      logic [11:0] ad [6] = '{12'h010, 12'h010, 12'h010, 12'h013, 12'h012, 12'h012};
      logic sg [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         do_req(i == 0, sz[i], sg[i], ad[i], 32'hDEADBEEF, v, rd, e);
         model_access(i == 0, sz[i], sg[i], int'(ad[i]), 32'hDEADBEEF, mrd, me);
         n_checks++;
         if (v !== 1'b1 || rd !== exp_d[i] || e !== 1'b0) begin
            n_fail++;
            $display("FAIL load_pattern_%0d valid=%b rdata=%h err=%b expected 1/%h/0", i, v, rd, e, exp_d[i]);
         end
      end
      do_req(0, 2'b00, 1, 12'h011, 0, v, rd, e);
      n_checks++;
      if (v !== 1'b1 || rd !== 32'hFFFFFFAD || e !== 1'b0) begin
         n_fail++;
         $display("FAIL load_byte_signed valid=%b rdata=%h err=%b expected 1/ffffffad/0", v, rd, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d [5] = '{32'hDEADBEEF, 32'h000000AD, 32'hFFFFBEEF, 32'hFFFFFFEF, 32'h000000DE};
      logic [1:0] sz [5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
      logic [11:0] ad [5] = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h010};
      logic sg [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         req_valid = 1; req_write = 0; req_size = sz[i]; req_signed = sg[i]; req_addr = ad[i];
         rsp_ready = (i < 4);
         if (i == 4) begin
            for (int c = 0; c < 3; c++) begin
               @(posedge CLK); #1;
               n_checks++;
               if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== exp_d[3]) begin
                  n_fail++;
                  $display("FAIL stall_hold_%0d ready=%b valid=%b rdata=%h expected 0/1/%h", c, req_ready, rsp_valid, rsp_rdata, exp_d[3]);
               end
            end
            @(negedge CLK); rsp_ready = 1;
         end
         @(posedge CLK); #1;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d[i] || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_%0d valid=%b rdata=%h err=%b expected 1/%h/0", i, rsp_valid, rsp_rdata, rsp_err, exp_d[i]);
         end
      end
      req_valid = 0;
      @(posedge CLK); #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain valid=%b expected 0", rsp_valid);
      end
   endtask

   task automatic test_misalign();
      logic v, e, me;
      logic [31:0] rd, mrd, exp_rd;
      logic exp_e;
`ifdef MISALIGN_TRAP_EN
      exp_e = 1; exp_rd = 32'h08080808;
`else
      exp_e = 0; exp_rd = 32'hCAFEF00D;
`endif
      do_req(1, 2'b10, 0, 12'h0FE, 32'hCAFEF00D, v, rd, e);
      model_access(1, 2'b10, 0, 12'h0FE, 32'hCAFEF00D, mrd, me);
      n_checks++;
      if (v !== 1'b1 || e !== exp_e || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL misalign_store valid=%b err=%b rdata=%h expected 1/%b/0", v, e, rd, exp_e);
      end
      do_req(0, 2'b10, 0, 12'h0FC, 0, v, rd, e);
      n_checks++;
      if (rd !== exp_rd || e !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_effect rdata=%h err=%b expected %h/0", rd, e, exp_rd);
      end
      do_req(1, 2'b11, 0, 12'h020, 32'hFFFFFFFF, v, rd, e);
      n_checks++;
      if (v !== 1'b1 || e !== 1'b1 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL reserved_store valid=%b err=%b rdata=%h expected 1/1/0", v, e, rd);
      end
      do_req(0, 2'b11, 1, 12'h010, 0, v, rd, e);
      n_checks++;
      if (e !== 1'b1 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL reserved_load err=%b rdata=%h expected 1/0", e, rd);
      end
      do_req(0, 2'b10, 0, 12'h020, 0, v, rd, e);
      n_checks++;
      if (rd !== 32'h08080808 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL reserved_no_write rdata=%h err=%b expected 08080808/0", rd, e);
      end
   endtask

   task automatic test_unwritten_and_async_reset();
      logic v, e;
      logic [31:0] rd;
      do_req(0, 2'b10, 0, 12'h300, 0, v, rd, e);
      n_checks++;
      if (rd !== 32'h08080808 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL unwritten rdata=%h err=%b expected 08080808/0", rd, e);
      end
      rsp_ready = 0;
      do_req(0, 2'b10, 0, 12'h010, 0, v, rd, e);
      rsp_ready = 0;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_valid got=%b expected 1", rsp_valid);
      end
      RST = 1; #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset valid=%b rdata=%h err=%b ready=%b expected 0/0/0/1", rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      @(negedge CLK); RST = 0;
      do_req(0, 2'b10, 0, 12'h010, 0, v, rd, e);
      n_checks++;
      if (v !== 1'b1 || rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL data_survives_reset valid=%b rdata=%h expected 1/deadbeef", v, rd);
      end
   endtask

   task automatic test_wrap();
      logic v, e, me;
      logic [31:0] rd, mrd;
      do_req(1, 2'b00, 0, 12'hFFF, 32'h0000007F, v, rd, e);
      model_access(1, 2'b00, 0, 12'hFFF, 32'h0000007F, mrd, me);
      do_req(0, 2'b00, 0, 12'hFFF, 0, v, rd, e);
      n_checks++;
      if (rd !== 32'h0000007F || e !== 1'b0) begin
         n_fail++;
         $display("FAIL top_byte rdata=%h err=%b expected 0000007f/0", rd, e);
      end
      do_req(0, 2'b00, 0, 12'h000, 0, v, rd, e);
      n_checks++;
      if (rd !== 32'h00000008) begin
         n_fail++;
         $display("FAIL addr0_intact rdata=%h expected 00000008", rd);
      end
   endtask

   task automatic test_random();
      logic v, e, me, w, sg;
      logic [1:0] sz;
      logic [11:0] a;
      logic [31:0] wd, rd, mrd;
      for (int i = 0; i < 400; i++) begin
         w  = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom_range(0, 1));
         a  = 12'($urandom_range(0, 63)) | ($urandom_range(0, 3) == 0 ? 12'hFC0 : 12'h100);
         wd = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 3) == 0) @(negedge CLK);
         do_req(w, sz, sg, a, wd, v, rd, e);
         model_access(w, sz, sg, int'(a), wd, mrd, me);
         n_checks++;
         if (v !== 1'b1 || rd !== mrd || e !== me) begin
            n_fail++;
            $display("FAIL random_%0d w=%b sz=%0d sg=%b a=%h wd=%h: valid=%b rdata=%h err=%b expected 1/%h/%b",
                     i, w, sz, sg, a, wd, v, rd, e, mrd, me);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h08;
      test_reset();
      test_loads();
      test_back_to_back();
      test_misalign();
      test_unwritten_and_async_reset();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
